// File: rtl/psx_pkg.sv
// Shared constants, state encoding and response-byte lookup for the
// DualShock (analog mode) device-side controller emulation.
package psx_pkg;

    localparam logic [7:0] START_CMD    = 8'h01;
    localparam logic [7:0] BEGIN_TX_CMD = 8'h42;
    localparam logic [7:0] ANALOG_ID    = 8'h73;
    localparam logic [7:0] PREAMBLE     = 8'h5A;
    localparam logic [7:0] IDLE_BYTE    = 8'hFF;

    localparam logic [3:0] NUM_POLL_BYTES = 4'd9;
    localparam logic [3:0] LAST_BYTE      = NUM_POLL_BYTES - 4'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ACK_WAIT,
        ST_ACK_PULSE,
        ST_IGNORE
    } psx_state_e;

    // Byte the controller shifts out at a given position of the poll.
    // Sticks are packed {rx, ry, lx, ly}, most significant byte first.
    function automatic logic [7:0] psx_tx_byte(input logic [3:0]  idx,
                                               input logic [15:0] btn,
                                               input logic [31:0] stk);
        logic [7:0] b;
        case (idx)
            4'd0:    b = IDLE_BYTE;
            4'd1:    b = ANALOG_ID;
            4'd2:    b = PREAMBLE;
            4'd3:    b = btn[7:0];
            4'd4:    b = btn[15:8];
            4'd5:    b = stk[31:24];
            4'd6:    b = stk[23:16];
            4'd7:    b = stk[15:8];
            4'd8:    b = stk[7:0];
            default: b = IDLE_BYTE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/psx_if.sv
// Controller-port pin bundle. The console drives att/psx_clk/cmd,
// the controller drives data/ack.
interface psx_if;
    logic att;
    logic psx_clk;
    logic cmd;
    logic data;
    logic ack;

    modport master (output att, psx_clk, cmd, input data, ack);
    modport slave  (input att, psx_clk, cmd, output data, ack);
endinterface

// File: rtl/psx_sync.sv
// Two-flop synchronizer for an idle-high pin, with registered one-cycle
// rise/fall pulses aligned to the cycle the synchronized level changes.
module psx_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Next synchronizer stage values and edge pulses against the old level.
    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        rise_d = s1_q & ~s2_q;
        fall_d = ~s1_q & s2_q;
    end

    // Flops load high on reset so an idle pin produces no spurious edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout = s2_q;
    assign rise = rise_q;
    assign fall = fall_q;
endmodule

// File: rtl/psx_controller.sv
// DualShock analog-mode (ID 0x73) device emulation: answers a console poll
// on the controller-port pins with snapshot button/stick state.
module psx_controller
    import psx_pkg::*;
#(
    parameter int ACK_DELAY = 64,
    parameter int ACK_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    psx_if.slave        pins,
    input  logic [15:0] button_state,
    input  logic [31:0] stick_state,
    output logic        poll_done
);
    localparam int CNT_W = 16;

    logic att_s, att_rise, att_fall;
    logic pclk_s, pclk_rise, pclk_fall;
    logic cmd_s1_q, cmd_s1_d, cmd_s2_q, cmd_s2_d;

    psx_state_e  state_q, state_d;
    logic [3:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  rx_q, rx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0] btn_q, btn_d;
    logic [31:0] stk_q, stk_d;
    logic        data_q, data_d;
    logic        ack_q, ack_d;
    logic        done_q, done_d;

    logic [7:0]  tx_cur, tx_next;
    logic        deselect;

    psx_sync u_att_sync (
        .clk(clk), .reset(reset), .din(pins.att),
        .dout(att_s), .rise(att_rise), .fall(att_fall)
    );

    psx_sync u_clk_sync (
        .clk(clk), .reset(reset), .din(pins.psx_clk),
        .dout(pclk_s), .rise(pclk_rise), .fall(pclk_fall)
    );

    // cmd only needs a level; it is sampled on the synchronized clock rise.
    always_comb begin
        cmd_s1_d = pins.cmd;
        cmd_s2_d = cmd_s1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_s1_q <= 1'b1;
            cmd_s2_q <= 1'b1;
        end else begin
            cmd_s1_q <= cmd_s1_d;
            cmd_s2_q <= cmd_s2_d;
        end
    end

    assign tx_cur  = psx_tx_byte(byte_idx_q, btn_q, stk_q);
    assign tx_next = psx_tx_byte(byte_idx_q + 4'd1, btn_q, stk_q);
    // att high while a poll is in progress also ends it (covers a rise
    // that coincided with reset).
    assign deselect = att_rise | (att_s & (state_q != ST_IDLE));

    // Poll FSM: next state, counters, snapshot and pin outputs.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        rx_d       = rx_q;
        cnt_d      = cnt_q;
        btn_d      = btn_q;
        stk_d      = stk_q;
        data_d     = data_q;
        ack_d      = ack_q;
        done_d     = 1'b0;

        if (deselect) begin
            state_d    = ST_IDLE;
            byte_idx_d = '0;
            bit_idx_d  = '0;
            cnt_d      = '0;
            data_d     = 1'b1;
            ack_d      = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    data_d = 1'b1;
                    ack_d  = 1'b1;
                    if (att_fall) begin
                        state_d    = ST_SHIFT;
                        byte_idx_d = '0;
                        bit_idx_d  = '0;
                        cnt_d      = '0;
                        btn_d      = button_state;
                        stk_d      = stick_state;
                    end
                end
                ST_SHIFT: begin
                    if (pclk_fall) begin
                        data_d = tx_cur[bit_idx_q];
                    end else if (pclk_rise) begin
                        rx_d[bit_idx_q] = cmd_s2_q;
                        bit_idx_d       = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            data_d = 1'b1;
                            cnt_d  = '0;
                            if (byte_idx_q == 4'd0) begin
                                state_d = (rx_d == START_CMD) ? ST_ACK_WAIT : ST_IGNORE;
                            end else if (byte_idx_q == 4'd1) begin
                                state_d = (rx_d == BEGIN_TX_CMD) ? ST_ACK_WAIT : ST_IGNORE;
                            end else if (byte_idx_q < LAST_BYTE) begin
                                state_d = ST_ACK_WAIT;
                            end else if (byte_idx_q == LAST_BYTE) begin
                                done_d     = 1'b1;
                                byte_idx_d = NUM_POLL_BYTES;
                            end
                        end
                    end
                end
                ST_ACK_WAIT, ST_ACK_PULSE: begin
                    if (pclk_fall) begin
                        // Console did not wait for ack: this edge is bit 0
                        // of the next byte.
                        state_d    = ST_SHIFT;
                        byte_idx_d = byte_idx_q + 4'd1;
                        bit_idx_d  = '0;
                        cnt_d      = '0;
                        ack_d      = 1'b1;
                        data_d     = tx_next[0];
                    end else if (state_q == ST_ACK_WAIT) begin
                        if (cnt_q == CNT_W'(ACK_DELAY - 1)) begin
                            state_d = ST_ACK_PULSE;
                            cnt_d   = '0;
                            ack_d   = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        if (cnt_q == CNT_W'(ACK_WIDTH - 1)) begin
                            state_d    = ST_SHIFT;
                            byte_idx_d = byte_idx_q + 4'd1;
                            bit_idx_d  = '0;
                            cnt_d      = '0;
                            ack_d      = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_IGNORE: begin
                    data_d = 1'b1;
                    ack_d  = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    data_d  = 1'b1;
                    ack_d   = 1'b1;
                end
            endcase
        end
    end

    // FSM and datapath registers; reset leaves the pins released.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            rx_q       <= '0;
            cnt_q      <= '0;
            btn_q      <= '1;
            stk_q      <= '0;
            data_q     <= 1'b1;
            ack_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            rx_q       <= rx_d;
            cnt_q      <= cnt_d;
            btn_q      <= btn_d;
            stk_q      <= stk_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
        end
    end

    assign pins.data = data_q;
    assign pins.ack  = ack_q;
    assign poll_done = done_q;

    // The synchronized clock level itself is not needed, only its edges.
    logic unused_ok;
    assign unused_ok = pclk_s;
endmodule
